// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher. Round keys are expanded into a local
// register file once per operation, then ten inverse rounds run one per
// clock. Byte 0 of data/key/de_data sits in the leftmost (MSB) bit positions,
// and bytes are ordered column-major as in FIPS-197.

package aes_decrypt_iter_pkg;

    // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1 (0x11B)
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        logic [7:0] bb;
        acc = '0;
        sh  = a;
        bb  = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bb[0]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; 0 maps to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int unsigned i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

endpackage

// Forward S-box: inverse in GF(2^8) followed by the affine transform
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    import aes_decrypt_iter_pkg::*;

    logic [7:0] b;

    assign b = gf_inv(a);
    assign s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform followed by the GF(2^8) inverse
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    import aes_decrypt_iter_pkg::*;

    logic [7:0] b;

    assign b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    assign s = gf_inv(b);
endmodule

module aes_decrypt_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] data,
    input  logic [0:127] key,
    output logic [0:127] de_data,
    output logic         busy,
    output logic         done
);
    import aes_decrypt_iter_pkg::*;

    typedef enum logic [2:0] {
        IDLE,
        KEXP,
        INIT,
        ROUND,
        FINAL
    } state_t;

    state_t       fsm_state;
    logic [3:0]   cnt;
    logic [127:0] ct_reg;
    logic [127:0] st_reg;
    logic [127:0] rk_file [11];

    logic [127:0] rk_cur;
    logic [127:0] rk_prev;
    logic [127:0] rk_next;
    logic [127:0] sub;
    logic [127:0] ark;
    logic [127:0] imc;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot;
    logic [31:0]  sw;
    logic [31:0]  n0, n1, n2, n3;
    logic [7:0]   rcon;

    // The same counter selects the key being written (KEXP) and the key being
    // applied (ROUND/FINAL); it is left at 0 on entry to FINAL so rk[0] is used.
    assign rk_cur  = rk_file[cnt];
    assign rk_prev = rk_file[cnt - 4'd1];

    // ---------------- key expansion: rk[cnt] from rk[cnt-1] ----------------
    assign {w0, w1, w2, w3} = rk_prev;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .a (rot[31-8*i -: 8]),
            .s (sw[31-8*i -: 8])
        );
    end

    // Round constant for the key currently being generated
    always_comb begin
        rcon = 8'h00;
        case (cnt)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign n0 = w0 ^ sw ^ {rcon, 24'h000000};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign rk_next = {n0, n1, n2, n3};

    // ------------- inverse round: InvShiftRows, InvSubBytes, ARK -----------
    // Row r of the output takes column (c - r) mod 4 of the input.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int SRC = 4 * ((c + 4 - r) % 4) + r;
            localparam int DST = 4 * c + r;
            aes_inv_sbox u_inv_sbox (
                .a (st_reg[127-8*SRC -: 8]),
                .s (sub[127-8*DST -: 8])
            );
        end
    end

    assign ark = sub ^ rk_cur;

    // InvMixColumns on each column of the key-added state
    for (genvar c = 0; c < 4; c++) begin : g_imc
        logic [7:0] a0, a1, a2, a3;
        assign a0 = ark[127-32*c -: 8];
        assign a1 = ark[119-32*c -: 8];
        assign a2 = ark[111-32*c -: 8];
        assign a3 = ark[103-32*c -: 8];
        assign imc[127-32*c -: 8] = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1)
                                  ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
        assign imc[119-32*c -: 8] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1)
                                  ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
        assign imc[111-32*c -: 8] = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1)
                                  ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
        assign imc[103-32*c -: 8] = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1)
                                  ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
    end

    // Control FSM, key file, cipher state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_state <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            de_data   <= '0;
            ct_reg    <= '0;
            st_reg    <= '0;
            rk_file   <= '{default: '0};
        end else begin
            done <= 1'b0;
            case (fsm_state)
                IDLE: begin
                    if (start) begin
                        ct_reg     <= data;
                        rk_file[0] <= key;
                        busy       <= 1'b1;
                        cnt        <= 4'd1;
                        fsm_state  <= KEXP;
                    end
                end
                KEXP: begin
                    rk_file[cnt] <= rk_next;
                    if (cnt == 4'd10) begin
                        fsm_state <= INIT;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                INIT: begin
                    st_reg    <= ct_reg ^ rk_file[10];
                    cnt       <= 4'd9;
                    fsm_state <= ROUND;
                end
                ROUND: begin
                    st_reg <= imc;
                    if (cnt == 4'd1) begin
                        cnt       <= '0;
                        fsm_state <= FINAL;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                FINAL: begin
                    de_data   <= ark;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    fsm_state <= IDLE;
                end
                default: begin
                    fsm_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: FIPS-197 vectors, protocol corner cases and a
// randomized round trip through a table-driven AES-128 encryptor model.

module tb_aes_decrypt_iter;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [0:127] data;
    logic [0:127] key;
    logic [0:127] de_data;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox_t [256];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    aes_decrypt_iter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data    (data),
        .key     (key),
        .de_data (de_data),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] aa;
        logic [7:0] bb;
        r  = '0;
        aa = a;
        bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) r = r ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return r;
    endfunction

    // S-box from its definition: brute-force inverse, then the affine map
    function automatic void build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] cc;
        logic       bitv;
        cc = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = 8'h00;
            for (int i = 0; i < 8; i++) begin
                bitv = 1'(inv >> i) ^ 1'(inv >> ((i + 4) % 8)) ^ 1'(inv >> ((i + 5) % 8))
                     ^ 1'(inv >> ((i + 6) % 8)) ^ 1'(inv >> ((i + 7) % 8)) ^ 1'(cc >> i);
                s = s | (8'(bitv) << i);
            end
            sbox_t[x] = s;
        end
    endfunction

    // Reference AES-128 encryptor (stands in for the team's encryptor)
    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] out;
        for (int i = 0; i < 4; i++) w[i] = 32'(k >> (32 * (3 - i)));
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
                    ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int j = 0; j < 16; j++)
            s[j] = 8'(p >> (8 * (15 - j))) ^ 8'(w[j / 4] >> (8 * (3 - j % 4)));
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int j = 0; j < 16; j++) t[j] = sbox_t[s[j]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r + 4 * c] = t[r + 4 * ((c + r) % 4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gm(8'h02, a0) ^ gm(8'h03, a1) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(8'h02, a1) ^ gm(8'h03, a2) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(8'h02, a2) ^ gm(8'h03, a3);
                    s[4*c+3] = gm(8'h03, a0) ^ a1 ^ a2 ^ gm(8'h02, a3);
                end
            end
            for (int j = 0; j < 16; j++)
                s[j] = s[j] ^ 8'(w[4 * rnd + j / 4] >> (8 * (3 - j % 4)));
        end
        out = '0;
        for (int j = 0; j < 16; j++) out = (out << 8) | 128'(s[j]);
        return out;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one operation (E0 = first edge after this call), optionally poke
    // start with fresh data/key just before edge poke_e, and report the number
    // of edges from E0 to done (-1 if none within the budget).
    task automatic run_op(input logic [127:0] k, input logic [127:0] d, input int poke_e,
                          output int lat, output logic busy_ok, output int extra_done);
        key   = k;
        data  = d;
        start = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        lat        = -1;
        busy_ok    = busy;
        extra_done = 0;
        for (int e = 1; e <= 40 && lat < 0; e++) begin
            if (e == poke_e) begin
                start = 1'b1;
                data  = rnd128();
                key   = rnd128();
            end
            @(posedge clk); #1;
            if (e == poke_e) start = 1'b0;
            if (done) lat = e;
            else if (!busy) busy_ok = 1'b0;
        end
        if (poke_e > 0) begin
            for (int e = 0; e < 25; e++) begin
                @(posedge clk); #1;
                if (done) extra_done++;
            end
        end
    endtask

    initial begin : main
        int           lat;
        int           xd;
        int           first;
        int           second;
        int           blow;
        logic         bok;
        logic         any_done;
        logic [127:0] k;
        logic [127:0] p;
        logic [127:0] c;
        logic [127:0] r1;
        logic [127:0] r2;

        build_sbox();
        rst_n = 1'b1;
        start = 1'b0;
        data  = '0;
        key   = '0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_de_data", de_data, '0);
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        #9 rst_n = 1'b1;

        // C.1 launched on the first edge after reset release
        run_op(C1_KEY, C1_CT, 0, lat, bok, xd);
        check("c1_latency", 128'(lat), 128'(21));
        check("c1_de_data", de_data, C1_PT);
        check("c1_busy_held", 128'(bok), 128'(1));
        check("c1_busy_at_done", 128'(busy), 128'(0));
        @(posedge clk); #1;
        check("c1_done_one_cycle", 128'(done), 128'(0));
        check("c1_de_data_hold", de_data, C1_PT);

        // Appendix B
        run_op(B_KEY, B_CT, 0, lat, bok, xd);
        check("appb_latency", 128'(lat), 128'(21));
        check("appb_de_data", de_data, B_PT);

        // start pulsed at E5 with different data/key must be ignored
        run_op(C1_KEY, C1_CT, 5, lat, bok, xd);
        check("busy_start_latency", 128'(lat), 128'(21));
        check("busy_start_de_data", de_data, C1_PT);
        check("busy_start_single_done", 128'(xd), 128'(0));
        check("busy_start_not_queued", 128'(busy), 128'(0));

        // Asynchronous reset in the middle of an operation
        key   = B_KEY;
        data  = B_CT;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_de_data", de_data, '0);
        check("midrst_done", 128'(done), 128'(0));
        any_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            any_done = any_done | done;
        end
        check("midrst_no_done", 128'(any_done), 128'(0));
        rst_n = 1'b1;
        run_op(B_KEY, B_CT, 0, lat, bok, xd);
        check("postrst_latency", 128'(lat), 128'(21));
        check("postrst_de_data", de_data, B_PT);

        // Random round trip, including all-zero and all-one keys
        for (int i = 0; i < 100; i++) begin
            if (i == 0)      k = '0;
            else if (i == 1) k = '1;
            else             k = rnd128();
            p = rnd128();
            c = aes_enc(k, p);
            run_op(k, c, 0, lat, bok, xd);
            check($sformatf("rt%0d_latency", i), 128'(lat), 128'(21));
            check($sformatf("rt%0d_plaintext", i), de_data, p);
        end

        // Back-to-back with start held high
        key    = C1_KEY;
        data   = C1_CT;
        start  = 1'b1;
        first  = -1;
        second = -1;
        blow   = 0;
        r1     = '0;
        r2     = '0;
        @(posedge clk); #1;
        for (int e = 1; e <= 60 && second < 0; e++) begin
            @(posedge clk); #1;
            if (e == 1) begin
                key  = B_KEY;
                data = B_CT;
            end
            if (done && first < 0) begin
                first = e;
                r1    = de_data;
            end else if (done) begin
                second = e;
                r2     = de_data;
                start  = 1'b0;
            end
            if (first >= 0 && second < 0 && !busy) blow++;
        end
        check("b2b_first_done", 128'(first), 128'(21));
        check("b2b_second_done", 128'(second), 128'(43));
        check("b2b_busy_gap", 128'(blow), 128'(1));
        check("b2b_first_data", r1, C1_PT);
        check("b2b_second_data", r2, B_PT);
        @(posedge clk); #1;
        check("b2b_idle_after", 128'(busy), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_iter.md
AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

Interface
- REQ-001: The block SHALL have no parameters; AES-128 only, 10 rounds fixed.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-004: start  input  1  request pulse; sampled only in IDLE.
- REQ-005: data  input  [0:127]  ciphertext; bit 0 = MSB of byte 0; bytes in FIPS-197 column-major order.
- REQ-006: key  input  [0:127]  cipher key, same bit/byte ordering as data.
- REQ-007: de_data  output  [0:127]  recovered plaintext, registered.
- REQ-008: busy  output  1  high from the edge that accepts start until the edge that asserts done.
- REQ-009: done  output  1  one-cycle pulse; de_data is valid from this cycle onward.

Function
- REQ-010: The block SHALL implement FIPS-197 AES-128 inverse cipher. It is the decrypting counterpart of the team's combinational encryptor main, with identical data/key bit ordering.
- REQ-011: The FSM SHALL use these states: IDLE, KEXP, INIT, ROUND, FINAL.
- REQ-012: IDLE with start=1 at edge E0 SHALL:
  - capture data and key into internal registers;
  - set busy=1;
  - clear the round counter to 1;
  - go to KEXP.
- REQ-013: KEXP SHALL compute round key rk[n] from rk[n-1] (RotWord, SubWord, Rcon[n]) at edges E1..E10. Each key is stored in an 11-entry round-key register file, with rk[0] = key. After E10 the FSM goes to INIT.
- REQ-014: INIT at E11 SHALL set state = ciphertext XOR rk[10]. The counter SHALL be set to 9.
- REQ-015: ROUND at E12..E20 SHALL perform one full inverse round per edge:
  - InvShiftRows, InvSubBytes, AddRoundKey rk[counter], InvMixColumns;
  - the counter decrements 9 down to 1;
  - leave for FINAL after counter = 1.
- REQ-016: FINAL at E21 SHALL:
  - set de_data = InvSubBytes(InvShiftRows(state)) XOR rk[0];
  - set done=1 and busy=0;
  - return to IDLE.
- REQ-017: Total latency SHALL be exactly 21 rising edges from the start-sampling edge E0 to the edge that raises done.
- REQ-018: done SHALL deassert on the following edge.
- REQ-019: de_data SHALL hold its value until the next FINAL or reset.
- REQ-020: start asserted while busy=1 SHALL be ignored. It is not queued, and captured data/key are not modified.
- REQ-021: Changes on data/key after E0 SHALL NOT affect the result in progress.
- REQ-022: start held high continuously SHALL launch a new operation on the edge following done, i.e. back-to-back ops every 22 cycles.
- REQ-023: The inverse S-box SHALL be combinational, with 16 instances for state bytes. The forward S-box SHALL be combinational, with 4 instances for SubWord. The round counter SHALL be 4 bits and SHALL never exceed 10.
- REQ-024: GF(2^8) multiplies in InvMixColumns SHALL use reduction polynomial 0x11B.

Reset
- REQ-025: rst_n=0 SHALL immediately, without waiting for clk, force:
  - FSM to IDLE, counter to 0;
  - busy=0, done=0;
  - de_data = 128'h0;
  - internal state, captured key and round-key file to 0.
- REQ-026: Reset mid-operation (any state) SHALL abort the operation with no done pulse.
- REQ-027: After rst_n returns high, the first start SHALL be accepted on the first rising edge with rst_n=1.

Verification
- REQ-028: FIPS-197 C.1:
  - stimulus: key=000102030405060708090a0b0c0d0e0f, data=69c4e0d86a7b0430d8cdb78070b4c55a;
  - response: de_data=00112233445566778899aabbccddeeff with done exactly 21 edges after start.
- REQ-029: FIPS-197 App. B:
  - stimulus: key=2b7e151628aed2a6abf7158809cf4f3c, data=3925841d02dc09fbdc118597196a0b32;
  - response: de_data=3243f6a8885a308d313198a2e0370734.
- REQ-030: Start while busy:
  - stimulus: launch C.1, then pulse start at E5 with different data and key;
  - response: C.1 result at E21 and a single done pulse.
- REQ-031: Reset mid-op:
  - stimulus: assert rst_n=0 asynchronously at E15;
  - response: busy=0 and de_data=0 immediately, no done; a fresh App. B run afterwards gives the correct result.
- REQ-032: Round trip:
  - stimulus: 100 random key/plaintext pairs encrypted by main, ciphertext fed to this block;
  - response: de_data equals the original plaintext every time, including key=0 and key=all-ones.
- REQ-033: Back-to-back:
  - stimulus: start held high for two operations;
  - response: done pulses at E21 and E43, busy low for exactly one cycle between them.
